// File: rtl/ahb2_mst_bridge_if.sv
// Command/response handshake and AHB-Lite master bus bundle for ahb2_mst_bridge.
// The master modport is the bridge's view; the slave modport is the surrounding system's view.
interface ahb2_mst_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] ahb_haddr;
  logic [1:0]            ahb_htrans;
  logic                  ahb_hwrite;
  logic [2:0]            ahb_hsize;
  logic [2:0]            ahb_hburst;
  logic [31:0]           ahb_hwdata;
  logic [31:0]           ahb_hrdata;
  logic                  ahb_hready;
  logic                  ahb_hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_err,
    input  rsp_ready,
    output ahb_haddr, ahb_htrans, ahb_hwrite, ahb_hsize, ahb_hburst, ahb_hwdata,
    input  ahb_hrdata, ahb_hready, ahb_hresp
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_err,
    output rsp_ready,
    input  ahb_haddr, ahb_htrans, ahb_hwrite, ahb_hsize, ahb_hburst, ahb_hwdata,
    output ahb_hrdata, ahb_hready, ahb_hresp
  );
endinterface

// File: rtl/ahb2_mst_bridge.sv
// Command/response to AHB-Lite single-word master bridge: address stage, data stage
// and an in-order response FIFO sized so every transfer in flight always has a slot.
module ahb2_mst_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int RSP_DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  ahb2_mst_bridge_if.master bus
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  logic                  run;
  logic                  a_v;
  logic [31:0]           a_wdata;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic                  hwrite_q;
  logic                  d_v;
  logic                  d_write;
  logic [31:0]           hwdata_q;

  logic [31:0]           fifo_rdata [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]  fifo_write;
  logic [RSP_DEPTH-1:0]  fifo_err;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW:0]           in_flight;

  logic accept;
  logic push;
  logic pop;

  // Slots already claimed: both pipeline stages plus queued responses.
  always_comb begin
    in_flight = {{CW{1'b0}}, a_v} + {{CW{1'b0}}, d_v} + {1'b0, count};
  end

  assign bus.cmd_ready = run & (~a_v | bus.ahb_hready) & (in_flight < (CW+1)'(RSP_DEPTH));
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign push          = d_v & bus.ahb_hready;
  assign pop           = (count != '0) & bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      run      <= 1'b0;
      a_v      <= 1'b0;
      a_wdata  <= '0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      d_v      <= 1'b0;
      d_write  <= 1'b0;
      hwdata_q <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      run <= 1'b1;
      if (bus.ahb_hready) begin
        d_v     <= a_v;
        d_write <= hwrite_q;
        if (a_v && hwrite_q) hwdata_q <= a_wdata;
      end
      // An empty A stage may be refilled even while the slave stalls.
      if (bus.ahb_hready || !a_v) a_v <= accept;
      if (accept) begin
        haddr_q  <= bus.cmd_addr & ~(ADDR_WIDTH'(3));
        hwrite_q <= bus.cmd_write;
        a_wdata  <= bus.cmd_wdata;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rdata[wr_ptr] <= d_write ? 32'h0 : bus.ahb_hrdata;
      fifo_write[wr_ptr] <= d_write;
      fifo_err[wr_ptr]   <= bus.ahb_hresp;
    end
  end

  // Response fields read as zero whenever the FIFO is empty, including during reset.
  assign bus.rsp_valid  = (count != '0);
  assign bus.rsp_write  = bus.rsp_valid & fifo_write[rd_ptr];
  assign bus.rsp_rdata  = bus.rsp_valid ? fifo_rdata[rd_ptr] : 32'h0;
  assign bus.rsp_err    = bus.rsp_valid & fifo_err[rd_ptr];

  assign bus.ahb_haddr  = haddr_q;
  assign bus.ahb_htrans = a_v ? 2'b10 : 2'b00;
  assign bus.ahb_hwrite = hwrite_q;
  assign bus.ahb_hsize  = 3'b010;
  assign bus.ahb_hburst = 3'b000;
  assign bus.ahb_hwdata = hwdata_q;

endmodule

// File: tb/tb_ahb2_mst_bridge.sv
// Directed bench for ahb2_mst_bridge with a small word-memory AHB slave whose
// read data is A500_0000 + word index unless written.
module tb_ahb2_mst_bridge;

  logic clk = 1'b0;
  logic rst;
  logic slv_hready;
  logic slv_hresp;
  int   checks = 0;
  int   errors = 0;

  ahb2_mst_bridge_if #(.ADDR_WIDTH(32)) bus ();

  ahb2_mst_bridge #(.ADDR_WIDTH(32), .RSP_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] slv_mem [128];
  logic        dp_valid;
  logic        dp_write;
  logic [6:0]  dp_idx;

  // Slave tracks its own data phase from the bus address phase.
  always @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      for (int i = 0; i < 128; i++) slv_mem[i] <= 32'hA500_0000 + i;
    end else if (slv_hready) begin
      if (dp_valid && dp_write) slv_mem[dp_idx] <= bus.ahb_hwdata;
      dp_valid <= bus.ahb_htrans[1];
      dp_write <= bus.ahb_hwrite;
      dp_idx   <= bus.ahb_haddr[8:2];
    end
  end

  assign bus.ahb_hrdata = (dp_valid && !dp_write) ? slv_mem[dp_idx] : 32'h0;
  assign bus.ahb_hready = slv_hready;
  assign bus.ahb_hresp  = slv_hresp;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (bus.ahb_htrans !== 2'b00) begin errors++; $display("[TB] FAIL reset_htrans got %h exp %h", bus.ahb_htrans, 2'b00); end
    checks++; if (bus.ahb_haddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_haddr got %h exp %h", bus.ahb_haddr, 32'h0); end
    checks++; if (bus.ahb_hwrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_hwrite got %b exp 0", bus.ahb_hwrite); end
    checks++; if (bus.ahb_hwdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_hwdata got %h exp 0", bus.ahb_hwdata); end
    checks++; if (bus.ahb_hsize !== 3'b010 || bus.ahb_hburst !== 3'b000) begin errors++; $display("[TB] FAIL reset_hsize_hburst got %b/%b exp 010/000", bus.ahb_hsize, bus.ahb_hburst); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_ready got %b exp 0", bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_write !== 1'b0 || bus.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_flags got %b/%b exp 0/0", bus.rsp_write, bus.rsp_err); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_rdata got %h exp 0", bus.rsp_rdata); end
    rst = 1'b0;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_cmd_ready got %b exp 1", bus.cmd_ready); end
  endtask

  task automatic test_zero_wait;
    tick();
    bus.rsp_ready = 1'b1;
    drive_cmd(1'b1, 32'h100, 32'hDEAD_BEEF);
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL zw_ready got %b exp 1", bus.cmd_ready); end
    tick();
    drive_cmd(1'b0, 32'h100, 32'h0);
    #1;
    checks++; if (bus.ahb_htrans !== 2'b10 || bus.ahb_haddr !== 32'h100 || bus.ahb_hwrite !== 1'b1) begin errors++; $display("[TB] FAIL zw_wr_addr got %h/%h/%b exp 2/100/1", bus.ahb_htrans, bus.ahb_haddr, bus.ahb_hwrite); end
    tick();
    bus.cmd_valid = 1'b0;
    #1;
    checks++; if (bus.ahb_htrans !== 2'b10 || bus.ahb_hwrite !== 1'b0) begin errors++; $display("[TB] FAIL zw_rd_addr got %h/%b exp 2/0", bus.ahb_htrans, bus.ahb_hwrite); end
    checks++; if (bus.ahb_hwdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL zw_hwdata got %h exp deadbeef", bus.ahb_hwdata); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL zw_early_rsp got %b exp 0", bus.rsp_valid); end
    tick();
    #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL zw_wr_rsp got v%b w%b %h e%b exp v1 w1 0 e0", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.rsp_err); end
    checks++; if (bus.ahb_htrans !== 2'b00) begin errors++; $display("[TB] FAIL zw_idle got %h exp 0", bus.ahb_htrans); end
    tick();
    #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0 || bus.rsp_rdata !== 32'hDEAD_BEEF || bus.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL zw_rd_rsp got v%b w%b %h e%b exp v1 w0 deadbeef e0", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.rsp_err); end
    tick();
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL zw_drained got %b exp 0", bus.rsp_valid); end
  endtask

  task automatic test_streaming;
    int got = 0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c < 8) drive_cmd(1'b0, 32'(c * 4), 32'h0);
      else bus.cmd_valid = 1'b0;
      #1;
      if (c < 8) begin
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready c%0d got %b exp 1", c, bus.cmd_ready); end
      end
      if (c >= 1 && c <= 8) begin
        checks++; if (bus.ahb_htrans !== 2'b10 || bus.ahb_haddr !== 32'((c - 1) * 4)) begin errors++; $display("[TB] FAIL stream_addr c%0d got %h/%h exp 2/%h", c, bus.ahb_htrans, bus.ahb_haddr, (c - 1) * 4); end
      end
      if (bus.rsp_valid) begin
        checks++; if (bus.rsp_rdata !== 32'hA500_0000 + 32'(got) || bus.rsp_write !== 1'b0) begin errors++; $display("[TB] FAIL stream_data %0d got %h exp %h", got, bus.rsp_rdata, 32'hA500_0000 + 32'(got)); end
        got++;
      end
    end
    checks++; if (got !== 8) begin errors++; $display("[TB] FAIL stream_count got %0d exp 8", got); end
  endtask

  task automatic test_wait_states;
    bus.rsp_ready = 1'b1;
    tick();
    drive_cmd(1'b1, 32'h20, 32'h1234_5678);
    #1;
    tick();
    drive_cmd(1'b0, 32'h24, 32'h0);
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL ws_ready got %b exp 1", bus.cmd_ready); end
    tick();
    bus.cmd_valid = 1'b0;
    slv_hready = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      if (w > 0) tick();
      checks++; if (bus.ahb_htrans !== 2'b10 || bus.ahb_haddr !== 32'h24 || bus.ahb_hwrite !== 1'b0) begin errors++; $display("[TB] FAIL ws_addr w%0d got %h/%h/%b exp 2/24/0", w, bus.ahb_htrans, bus.ahb_haddr, bus.ahb_hwrite); end
      checks++; if (bus.ahb_hwdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL ws_hwdata w%0d got %h exp 12345678", w, bus.ahb_hwdata); end
      checks++; if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL ws_stall w%0d got ready%b rsp%b exp 0/0", w, bus.cmd_ready, bus.rsp_valid); end
    end
    tick();
    slv_hready = 1'b1;
    #1;
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL ws_wr_rsp got v%b w%b %h e%b exp v1 w1 0 e0", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.rsp_err); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0 || bus.rsp_rdata !== 32'hA500_0009) begin errors++; $display("[TB] FAIL ws_rd_rsp got v%b w%b %h exp v1 w0 a5000009", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL ws_drained got %b exp 0", bus.rsp_valid); end
  endtask

  task automatic test_error;
    tick();
    drive_cmd(1'b0, 32'h40, 32'h0);
    #1;
    tick();
    drive_cmd(1'b0, 32'h44, 32'h0);
    #1;
    tick();
    bus.cmd_valid = 1'b0;
    slv_hready = 1'b0;
    slv_hresp  = 1'b1;
    #1;
    checks++; if (bus.ahb_htrans !== 2'b10 || bus.ahb_haddr !== 32'h44 || bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_first got %h/%h/%b exp 2/44/0", bus.ahb_htrans, bus.ahb_haddr, bus.rsp_valid); end
    tick();
    slv_hready = 1'b1;
    #1;
    checks++; if (bus.ahb_htrans !== 2'b10 || bus.ahb_haddr !== 32'h44) begin errors++; $display("[TB] FAIL err_second got %h/%h exp 2/44", bus.ahb_htrans, bus.ahb_haddr); end
    tick();
    slv_hresp = 1'b0;
    bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_write !== 1'b0) begin errors++; $display("[TB] FAIL err_rsp got v%b e%b w%b exp 1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_write); end
    tick();
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL err_hold got %b exp 1", bus.rsp_err); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hA500_0011) begin errors++; $display("[TB] FAIL err_next got v%b e%b %h exp 1/0/a5000011", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_drained got %b exp 0", bus.rsp_valid); end
  endtask

  task automatic test_backpressure;
    int k   = 0;
    int got = 0;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (k < 6) drive_cmd(1'b0, 32'(k * 4), 32'h0);
      else bus.cmd_valid = 1'b0;
      #1;
      if (bus.cmd_valid && bus.cmd_ready) k++;
    end
    checks++; if (k !== 4) begin errors++; $display("[TB] FAIL bp_accepted got %0d exp 4", k); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready got %b exp 0", bus.cmd_ready); end
    for (int c = 0; c < 40 && got < 6; c++) begin
      tick();
      bus.rsp_ready = 1'b1;
      if (k < 6) drive_cmd(1'b0, 32'(k * 4), 32'h0);
      else bus.cmd_valid = 1'b0;
      #1;
      if (bus.cmd_valid && bus.cmd_ready) k++;
      if (bus.rsp_valid) begin
        checks++; if (bus.rsp_rdata !== 32'hA500_0000 + 32'(got)) begin errors++; $display("[TB] FAIL bp_data %0d got %h exp %h", got, bus.rsp_rdata, 32'hA500_0000 + 32'(got)); end
        got++;
      end
    end
    bus.cmd_valid = 1'b0;
    checks++; if (got !== 6 || k !== 6) begin errors++; $display("[TB] FAIL bp_total got rsp%0d cmd%0d exp 6/6", got, k); end
  endtask

  task automatic test_reset_mid;
    bus.rsp_ready = 1'b1;
    tick();
    drive_cmd(1'b0, 32'h30, 32'h0);
    #1;
    tick();
    drive_cmd(1'b0, 32'h34, 32'h0);
    #1;
    tick();
    bus.cmd_valid = 1'b0;
    slv_hready = 1'b0;
    rst = 1'b1;
    #1;
    tick();
    checks++; if (bus.ahb_htrans !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.ahb_haddr !== 32'h0 || bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_reset got %h/%b/%h/%b exp 0/0/0/0", bus.ahb_htrans, bus.rsp_valid, bus.ahb_haddr, bus.cmd_ready); end
    rst = 1'b0;
    slv_hready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_stale c%0d got %b exp 0", i, bus.rsp_valid); end
    end
    tick();
    drive_cmd(1'b0, 32'h8, 32'h0);
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_ready got %b exp 1", bus.cmd_ready); end
    tick();
    bus.cmd_valid = 1'b0;
    #1;
    tick();
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0 || bus.rsp_rdata !== 32'hA500_0002) begin errors++; $display("[TB] FAIL rm_recover got v%b w%b %h exp 1/0/a5000002", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata); end
  endtask

  initial begin
    rst           = 1'b1;
    slv_hready    = 1'b1;
    slv_hresp     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_zero_wait();
    test_streaming();
    test_wait_states();
    test_error();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
